// File: rtl/pipelined_addsub_nbits_if.sv
// pipelined_addsub_nbits_if: operand/result bundle of the segment-pipelined adder/subtractor
interface pipelined_addsub_nbits_if #(
    parameter int WIDTH = 14
);
    logic             ce_i;
    logic             in_valid_i;
    logic             mode_i;
    logic             cin_i;
    logic [WIDTH-1:0] ain_i;
    logic [WIDTH-1:0] bin_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;
    logic             out_valid_o;

    modport master (
        output ce_i, in_valid_i, mode_i, cin_i, ain_i, bin_i,
        input  sum_o, carry_o, overflow_o, out_valid_o
    );

    modport slave (
        input  ce_i, in_valid_i, mode_i, cin_i, ain_i, bin_i,
        output sum_o, carry_o, overflow_o, out_valid_o
    );
endinterface

// File: rtl/pipelined_addsub_nbits.sv
// pipelined_addsub_nbits: segment-pipelined add/subtract with carry-in, valid tracking, signed overflow and optional saturation
module pipelined_addsub_nbits #(
    parameter int WIDTH    = 14,
    parameter int SEG_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    pipelined_addsub_nbits_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int MSB  = SEG_W - 1;

    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic [SEG_W-1:0] op_a    [NSEG];
    logic [SEG_W-1:0] op_b    [NSEG];
    logic             seg_ci  [NSEG];
    logic [SEG_W:0]   seg_add [NSEG];
    logic             seg_cy  [NSEG];
    logic [SEG_W-1:0] aligned [NSEG];
    logic [NSEG-1:0]  vld_q;
    logic             ov_q;
    logic             pos_q;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             valid_q;

    assign b_eff = bus.mode_i ? ~bus.bin_i : bus.bin_i;
    assign cin0  = bus.mode_i | bus.cin_i;

    genvar s;
    for (s = 0; s < NSEG; s++) begin : g_seg
        logic [SEG_W-1:0] sum_seg_q;
        logic             cy_seg_q;
        if (s == 0) begin : g_head
            assign op_a[s]   = bus.ain_i[SEG_W-1:0];
            assign op_b[s]   = b_eff[SEG_W-1:0];
            assign seg_ci[s] = cin0;
        end else begin : g_skew
            logic [SEG_W-1:0] a_sk_q [s];
            logic [SEG_W-1:0] b_sk_q [s];
            // Delay this segment's operand slices by s stages so they meet the rippling carry.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int j = 0; j < s; j++) begin
                        a_sk_q[j] <= '0;
                        b_sk_q[j] <= '0;
                    end
                end else if (bus.ce_i) begin
                    a_sk_q[0] <= bus.ain_i[s*SEG_W +: SEG_W];
                    b_sk_q[0] <= b_eff[s*SEG_W +: SEG_W];
                    for (int j = 1; j < s; j++) begin
                        a_sk_q[j] <= a_sk_q[j-1];
                        b_sk_q[j] <= b_sk_q[j-1];
                    end
                end
            end
            assign op_a[s]   = a_sk_q[s-1];
            assign op_b[s]   = b_sk_q[s-1];
            assign seg_ci[s] = seg_cy[s-1];
        end
        assign seg_add[s] = {1'b0, op_a[s]} + {1'b0, op_b[s]} + {{SEG_W{1'b0}}, seg_ci[s]};
        // Register this segment's partial sum and the carry handed to the next segment.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sum_seg_q <= '0;
                cy_seg_q  <= 1'b0;
            end else if (bus.ce_i) begin
                sum_seg_q <= seg_add[s][SEG_W-1:0];
                cy_seg_q  <= seg_add[s][SEG_W];
            end
        end
        assign seg_cy[s] = cy_seg_q;
        if (s == NSEG - 1) begin : g_tail
            assign aligned[s] = sum_seg_q;
        end else begin : g_deskew
            logic [SEG_W-1:0] dsk_q [NSEG-1-s];
            // Hold early slices back until the top segment has finished.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int j = 0; j < NSEG - 1 - s; j++) dsk_q[j] <= '0;
                end else if (bus.ce_i) begin
                    dsk_q[0] <= sum_seg_q;
                    for (int j = 1; j < NSEG - 1 - s; j++) dsk_q[j] <= dsk_q[j-1];
                end
            end
            assign aligned[s] = dsk_q[NSEG-2-s];
        end
    end

    // Top segment: carry into the MSB is recovered as a^b^sum at that bit; also note a positive-overflow direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ov_q  <= 1'b0;
            pos_q <= 1'b0;
        end else if (bus.ce_i) begin
            ov_q  <= op_a[NSEG-1][MSB] ^ op_b[NSEG-1][MSB] ^ seg_add[NSEG-1][MSB] ^ seg_add[NSEG-1][SEG_W];
            pos_q <= ~(op_a[NSEG-1][MSB] | op_b[NSEG-1][MSB]);
        end
    end

    // Reassemble the aligned slices into the full-width result.
    always_comb begin
        sum_raw = '0;
        for (int i = 0; i < NSEG; i++) sum_raw[i*SEG_W +: SEG_W] = aligned[i];
    end

    assign sum_d = (SATURATE != 0 && ov_q)
                 ? (pos_q ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}})
                 : sum_raw;

    // Valid bits ride alongside the data, one per stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_q <= '0;
        else if (bus.ce_i) vld_q <= (vld_q << 1) | NSEG'(bus.in_valid_i);
    end

    // Final output register: result, unclamped flags and valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.ce_i) begin
            sum_q   <= sum_d;
            carry_q <= seg_cy[NSEG-1];
            ovf_q   <= ov_q;
            valid_q <= vld_q[NSEG-1];
        end
    end

    assign bus.sum_o       = sum_q;
    assign bus.carry_o     = carry_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.out_valid_o = valid_q;
endmodule

// File: tb/tb_pipelined_addsub_nbits.sv
// tb_pipelined_addsub_nbits: random and directed checks of three adder configurations against an arithmetic model
module tb_pipelined_addsub_nbits;
    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
    } res_t;
    typedef struct {
        int   due;
        res_t r;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        in_valid;
    logic        mode;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    int          n_chk = 0;
    int          n_fail = 0;
    int          ecnt = 0;
    ent_t        q [3][$];
    int          wv  [3] = '{14, 14, 32};
    int          lat [3] = '{7, 7, 8};
    bit          satv [3] = '{1'b0, 1'b1, 1'b0};

    pipelined_addsub_nbits_if #(.WIDTH(14)) i0 ();
    pipelined_addsub_nbits_if #(.WIDTH(14)) i1 ();
    pipelined_addsub_nbits_if #(.WIDTH(32)) i2 ();

    assign i0.ce_i = ce;  assign i0.in_valid_i = in_valid;  assign i0.mode_i = mode;  assign i0.cin_i = cin;
    assign i0.ain_i = a[13:0];  assign i0.bin_i = b[13:0];
    assign i1.ce_i = ce;  assign i1.in_valid_i = in_valid;  assign i1.mode_i = mode;  assign i1.cin_i = cin;
    assign i1.ain_i = a[13:0];  assign i1.bin_i = b[13:0];
    assign i2.ce_i = ce;  assign i2.in_valid_i = in_valid;  assign i2.mode_i = mode;  assign i2.cin_i = cin;
    assign i2.ain_i = a;  assign i2.bin_i = b;

    pipelined_addsub_nbits #(.WIDTH(14), .SEG_W(2), .SATURATE(0)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(i0.slave));
    pipelined_addsub_nbits #(.WIDTH(14), .SEG_W(2), .SATURATE(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(i1.slave));
    pipelined_addsub_nbits #(.WIDTH(32), .SEG_W(4), .SATURATE(0)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(i2.slave));

    always #5 clk = ~clk;

    function automatic res_t model(int w, bit sat, logic [31:0] aa, logic [31:0] bb, logic m, logic ci);
        logic [63:0] mask, am, bm, full;
        res_t r;
        mask  = (64'd1 << w) - 64'd1;
        am    = {32'd0, aa} & mask;
        bm    = (m ? ~{32'd0, bb} : {32'd0, bb}) & mask;
        full  = am + bm + {63'd0, m | ci};
        r.sum = 32'(full & mask);
        r.c   = full[w];
        r.v   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        if (sat && r.v) r.sum = 32'(am[w-1] ? (mask ^ (mask >> 1)) : (mask >> 1));
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference pipeline: each accepted op becomes due a fixed number of enabled edges later.
    always @(posedge clk) begin
        if (rst_n && ce) begin
            ecnt++;
            for (int i = 0; i < 3; i++) begin
                ent_t e;
                while (q[i].size() > 0 && q[i][0].due < ecnt) void'(q[i].pop_front());
                if (in_valid) begin
                    e.due = ecnt + lat[i];
                    e.r   = model(wv[i], satv[i], a, b, mode, cin);
                    q[i].push_back(e);
                end
            end
        end
    end

    always @(negedge rst_n) for (int i = 0; i < 3; i++) q[i].delete();

    task automatic cmp(int i, logic v, logic [31:0] s, logic c, logic o);
        logic ev;
        res_t r;
        if (!rst_n) begin
            chk($sformatf("u%0d reset sum", i), s, 32'd0);
            chk($sformatf("u%0d reset flags", i), {29'd0, v, c, o}, 32'd0);
            return;
        end
        ev = q[i].size() > 0 && q[i][0].due == ecnt;
        chk($sformatf("u%0d out_valid", i), 32'(v), 32'(ev));
        if (ev) begin
            r = q[i][0].r;
            chk($sformatf("u%0d sum", i), s, r.sum);
            chk($sformatf("u%0d carry", i), 32'(c), 32'(r.c));
            chk($sformatf("u%0d overflow", i), 32'(o), 32'(r.v));
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        cmp(0, i0.out_valid_o, 32'(i0.sum_o), i0.carry_o, i0.overflow_o);
        cmp(1, i1.out_valid_o, 32'(i1.sum_o), i1.carry_o, i1.overflow_o);
        cmp(2, i2.out_valid_o, i2.sum_o, i2.carry_o, i2.overflow_o);
    end

    task automatic drive(logic c_e, logic v, logic m, logic ci, logic [31:0] aa, logic [31:0] bb);
        @(posedge clk);
        #1;
        ce = c_e; in_valid = v; mode = m; cin = ci; a = aa; b = bb;
    endtask

    task automatic drive_rand(logic c_e, logic v);
        drive(c_e, v, 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic directed(string nm, logic [31:0] aa, logic [31:0] bb, logic m, logic ci,
                            logic [31:0] s0, logic c0, logic o0, logic [31:0] s1, logic [31:0] s2);
        drive(1'b1, 1'b1, m, ci, aa, bb);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (7) @(posedge clk);
        #2;
        chk({nm, " u0 valid"}, 32'(i0.out_valid_o), 32'd1);
        chk({nm, " u0 sum"}, 32'(i0.sum_o), s0);
        chk({nm, " u0 carry"}, 32'(i0.carry_o), 32'(c0));
        chk({nm, " u0 ovf"}, 32'(i0.overflow_o), 32'(o0));
        chk({nm, " u1 sum"}, 32'(i1.sum_o), s1);
        chk({nm, " u1 ovf"}, 32'(i1.overflow_o), 32'(o0));
        chk({nm, " u2 early"}, 32'(i2.out_valid_o), 32'd0);
        @(posedge clk);
        #2;
        chk({nm, " u0 single"}, 32'(i0.out_valid_o), 32'd0);
        chk({nm, " u2 valid"}, 32'(i2.out_valid_o), 32'd1);
        chk({nm, " u2 sum"}, i2.sum_o, s2);
    endtask

    initial begin
        res_t r;
        logic [13:0] snap_s;
        logic        snap_v;
        int          n, n0, n2;
        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        r = model(14, 1'b0, 32'h3fff, 32'h1, 1'b0, 1'b0);
        chk("model wrap sum", r.sum, 32'h0);
        chk("model wrap carry", 32'(r.c), 32'd1);
        r = model(14, 1'b0, 32'h5, 32'h7, 1'b1, 1'b0);
        chk("model sub sum", r.sum, 32'h3ffe);
        chk("model sub borrow", 32'(r.c), 32'd0);
        r = model(14, 1'b1, 32'h1fff, 32'h1, 1'b0, 1'b0);
        chk("model sat pos", r.sum, 32'h1fff);
        chk("model sat ovf", 32'(r.v), 32'd1);
        r = model(14, 1'b1, 32'h2000, 32'h3fff, 1'b0, 1'b0);
        chk("model sat neg", r.sum, 32'h2000);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        directed("wrap", 32'h3fff, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000);
        directed("sub5m7", 32'h5, 32'h7, 1'b1, 1'b0, 32'h3ffe, 1'b0, 1'b0, 32'h3ffe, 32'hfffffffe);
        directed("sub7m5", 32'h7, 32'h5, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 32'h2, 32'h2);
        directed("cin", 32'h3, 32'h4, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h8, 32'h8);
        directed("ovf_pos", 32'h1fff, 32'h1, 1'b0, 1'b0, 32'h2000, 1'b0, 1'b1, 32'h1fff, 32'h2000);
        directed("ovf_neg", 32'h2000, 32'h3fff, 1'b0, 1'b0, 32'h1fff, 1'b1, 1'b1, 32'h2000, 32'h5fff);

        repeat (100) drive_rand(1'b1, 1'b1);
        drive_rand(1'b0, 1'b1);
        snap_s = i0.sum_o;
        snap_v = i0.out_valid_o;
        drive_rand(1'b0, 1'b1);
        drive_rand(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("stall hold sum", 32'(i0.sum_o), 32'(snap_s));
        chk("stall hold valid", 32'(i0.out_valid_o), 32'(snap_v));
        ce = 1'b1; in_valid = 1'b0;
        repeat (20) drive_rand(1'b1, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        repeat (300) drive(($urandom % 4) != 0, ($urandom % 4) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        repeat (4) drive_rand(1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async rst u0 sum", 32'(i0.sum_o), 32'd0);
        chk("async rst u0 valid", 32'(i0.out_valid_o), 32'd0);
        chk("async rst u2 sum", i2.sum_o, 32'd0);
        chk("async rst u2 flags", {30'd0, i2.carry_o, i2.out_valid_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive_rand(1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0; n0 = 0; n2 = 0;
        while (n < 20 && (n0 == 0 || n2 == 0)) begin
            @(posedge clk);
            n++;
            #2;
            if (n0 == 0 && i0.out_valid_o) n0 = n;
            if (n2 == 0 && i2.out_valid_o) n2 = n;
        end
        chk("post-reset latency u0", 32'(n0), 32'd7);
        chk("post-reset latency u2", 32'(n2), 32'd8);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub_nbits.md
Name: pipelined_addsub_nbits

Overview:
- Parametrised, segment-pipelined adder/subtractor; next generation of the team's fixed 14-bit pipelined adder.
- Splits WIDTH-bit operands into SEG_W-bit segments. Each segment's carry ripples one pipeline stage per segment, so fmax is set by a SEG_W-bit add, not a WIDTH-bit add.
- Adds what the 14-bit block lacks: add/subtract mode, carry-in, valid tracking, pipeline clock-enable, signed overflow flag and optional signed saturation.
- Used in the function-generator datapath for phase accumulation, offset and amplitude arithmetic.

Parameters:
- WIDTH, 14, operand/result width; must be an integer multiple of SEG_W.
- SEG_W, 2, bits added per pipeline stage; NSEG = WIDTH/SEG_W.
- SATURATE, 0, 1 = clamp the signed result on overflow; 0 = wrap.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- Ce  in  1  pipeline enable; 0 freezes every register, including valid bits.
- In_valid  in  1  operands valid this cycle.
- Mode  in  1  0 = A+B+Cin; 1 = A-B (implemented as A+~B+1, Cin ignored).
- Cin  in  1  carry-in, add mode only.
- Ain  in  WIDTH  operand A.
- Bin  in  WIDTH  operand B.
- Sum_out  out  WIDTH  result.
- Carry_out  out  1  carry out of the MSB; in subtract mode 1 = no borrow.
- Overflow  out  1  two's-complement signed overflow of this result.
- Out_valid  out  1  Sum_out, Carry_out and Overflow are valid.

Behaviour:
- Reset (Reset=0, asynchronous): all pipeline, skew and valid registers and all outputs go to 0.
- Outputs stay 0 until Reset=1 and the first valid result emerges.
- Sampling: Ain, Bin, Mode, Cin and In_valid are sampled at every rising edge where Ce=1. In_valid is carried down a valid shift chain alongside the data.
- Segment s (s = 0..NSEG-1):
  - The A and B slices enter s-deep input skew registers; Bin is inverted before skewing when Mode=1.
  - Its SEG_W-bit adder is registered and takes its carry from segment s-1's registered carry.
  - Segment 0 carry-in = Mode ? 1 : Cin.
  - Each completed sum slice passes through (NSEG-1-s) deskew registers so all slices align.
- Output stage: a final register captures:
  - the aligned sum;
  - the MSB carry (Carry_out);
  - Overflow = (carry into MSB) XOR (carry out of MSB).
  - The carry into the MSB is taken from the last segment's internal bit carry.
- Saturation:
  - SATURATE=0: Sum_out is the raw result.
  - SATURATE=1 and Overflow=1: Sum_out = 0 followed by WIDTH-1 ones when the result overflowed positive (both operands' effective signs 0), else 1 followed by WIDTH-1 zeros.
  - Overflow and Carry_out are reported unclamped either way.
- Latency: operands sampled at edge k appear on the outputs, with Out_valid=1, immediately after edge k+NSEG (WIDTH=14, SEG_W=2: edge k+7).
- Throughput: one result per enabled cycle; back-to-back In_valid is fully supported.
- In_valid=0 bubbles propagate as Out_valid=0. Data registers may still update; their contents are don't-care while Out_valid=0.
- Ce=0: every register holds, outputs hold, and no carry advances. Ce toggling never corrupts in-flight results; latency counts enabled edges only.
- Mode and Cin are per-operation and travel with their data, so mixing adds and subtracts on consecutive cycles is legal.
- Reset asserted mid-stream: all in-flight results are discarded. After release, Out_valid stays 0 until new inputs have traversed NSEG enabled edges.
- No back-pressure: the consumer must accept Out_valid whenever it is high, or hold Ce=0.

Test Plan:
- Wrap add, WIDTH=14: A=0x3FFF, B=0x0001, Cin=0, Mode=0 -> 7 edges later: Sum_out=0x0000, Carry_out=1, Overflow=0, Out_valid=1 for exactly 1 cycle.
- Subtract: A=5, B=7, Mode=1 -> Sum_out=0x3FFE, Carry_out=0 (borrow), Overflow=0. Then A=7, B=5 -> Sum_out=0x0002, Carry_out=1.
- Signed overflow: A=0x1FFF, B=0x0001, add:
  - SATURATE=0 -> Sum_out=0x2000, Overflow=1.
  - SATURATE=1 -> Sum_out=0x1FFF, Overflow=1.
  - A=0x2000, B=0x3FFF, SATURATE=1 -> Sum_out=0x2000, Overflow=1.
- Streaming: 100 back-to-back random add/sub operations with random Cin -> outputs match a reference model in order, with Out_valid continuously high from edge 7 onward.
- Stall: Ce=0 for 3 cycles mid-stream, plus one In_valid=0 gap -> no result lost or duplicated, outputs held during the stall, exactly one Out_valid=0 cycle for the bubble.
- Reset: pull Reset low asynchronously between clock edges with 4 results in flight -> all outputs 0 immediately. After release, the first Out_valid comes exactly 7 edges after the first new In_valid. Repeat with WIDTH=32, SEG_W=4: latency 8.
